// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - sweeps a ram address window and re-emits each byte as a valid/ready stream
// Reads are credit-limited so the elastic FIFO can absorb every in-flight word under backpressure.
module ram_stream_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);
  localparam int PW  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int FCW = $clog2(FIFO_D + 1);
  localparam int CW  = $clog2(FIFO_D + RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W:0]   acc_cnt;
  logic [RD_LAT-1:0] tag;
  logic [DATA_W-1:0] mem [FIFO_D];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [FCW-1:0]    fifo_count;
  logic [CW-1:0]     inflight;
  logic              kick;
  logic              issue;
  logic              push;
  logic              pop;
  logic              flush;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(tag[i]);
  end

  assign kick  = (state == IDLE) && start && (length != '0);
  assign flush = abort && ((state == READ) || (state == DRAIN));
  // A read is only issued when its word is guaranteed a FIFO slot on arrival.
  assign issue = kick || ((state == READ) && !abort &&
                          ((CW'(fifo_count) + inflight) < CW'(FIFO_D)));
  assign push  = tag[RD_LAT-1];
  assign pop   = m_valid && m_ready;

  // The first read leaves on the start edge itself, so the window base bypasses addr_q.
  assign ram_addr  = ((state == IDLE) && start) ? base_addr : addr_q;
  assign ram_wren  = 1'b0;
  assign ram_wdata = '0;
  assign busy      = (state != IDLE);
  assign m_valid   = (fifo_count != '0);
  assign m_data    = mem[rd_ptr];
  assign m_last    = m_valid && (acc_cnt == len - (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      addr_q    <= '0;
      len       <= '0;
      issue_cnt <= '0;
      acc_cnt   <= '0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          len     <= length;
          acc_cnt <= '0;
          if (length == '0) begin
            state <= DONE;
          end else begin
            addr_q    <= base_addr + ADDR_W'(1);
            issue_cnt <= (ADDR_W+1)'(1);
            state     <= (length == (ADDR_W+1)'(1)) ? DRAIN : READ;
          end
        end
        READ: if (abort) begin
          state <= IDLE;
        end else begin
          if (issue) begin
            addr_q    <= addr_q + ADDR_W'(1);
            issue_cnt <= issue_cnt + (ADDR_W+1)'(1);
            if (issue_cnt == len - (ADDR_W+1)'(1)) state <= DRAIN;
          end
          if (pop) acc_cnt <= acc_cnt + (ADDR_W+1)'(1);
        end
        DRAIN: if (abort) begin
          state <= IDLE;
        end else if (pop) begin
          acc_cnt <= acc_cnt + (ADDR_W+1)'(1);
          if (acc_cnt == len - (ADDR_W+1)'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_D; i++) mem[i] <= '0;
    end else if (flush) begin
      tag        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      tag[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) tag[i] <= tag[i-1];
      if (push) begin
        mem[wr_ptr] <= ram_q;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) fifo_count <= fifo_count + FCW'(1);
      else if (!push && pop) fifo_count <= fifo_count - FCW'(1);
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (fifo_count == FCW'(FIFO_D))));

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - scoreboard bench for ram_stream_reader against a 1024x8 ram model
module tb_ram_stream_reader;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic        abort;
  logic        busy;
  logic        done;
  logic [9:0]  ram_addr;
  logic        ram_wren;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_q;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  logic [7:0]  ram [1024];
  logic [8:0]  exp_q [$];
  int          checks;
  int          errors;

  ram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .busy(busy), .done(done), .ram_addr(ram_addr), .ram_wren(ram_wren),
    .ram_wdata(ram_wdata), .ram_q(ram_q), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) ram[ram_addr] <= ram_wdata;
    ram_q <= ram[ram_addr];
  end

  // Expected beats carry {last, data}; the window wraps at the ram size.
  task automatic issue_start(input int base, input int len, input bit track);
    @(negedge clk);
    start     = 1'b1;
    base_addr = 10'(base);
    length    = 11'(len);
    if (track)
      for (int i = 0; i < len; i++)
        exp_q.push_back({(i == len - 1), ram[(base + i) % 1024]});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, m_valid, m_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/valid/last=%b expected 0000", {busy, done, m_valid, m_last});
    end
    checks++;
    if (m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: m_data=%h expected 00", m_data);
    end
    checks++;
    if (ram_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_addr: ram_addr=%0d expected 0", ram_addr);
    end
    checks++;
    if ({ram_wren, ram_wdata} !== 9'd0) begin
      errors++;
      $display("FAIL reset_wr: wren/wdata=%h expected 0", {ram_wren, ram_wdata});
    end
  endtask

  task automatic test_transfer(input int base, input int len, input bit rnd);
    int first, last_c, done_at, beats;
    bit hold;
    logic [7:0] held;
    logic [8:0] e;
    first = -1; last_c = -1; done_at = -1; beats = 0; hold = 1'b0; held = '0;
    m_ready = 1'b1;
    issue_start(base, len, 1'b1);
    for (int c = 1; c <= len * 4 + 20 && done_at < 0; c++) begin
      @(negedge clk);
      if (hold) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          errors++;
          $display("FAIL stable: valid=%b data=%h expected valid=1 data=%h", m_valid, m_data, held);
        end
      end
      m_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (m_valid === 1'b1) begin
        if (first < 0) first = c;
        if (m_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat: data=%h with empty scoreboard", m_data);
          end else begin
            e = exp_q.pop_front();
            if ({m_last, m_data} !== e) begin
              errors++;
              $display("FAIL beat: last/data=%b/%h expected %b/%h", m_last, m_data, e[8], e[7:0]);
            end
          end
          beats++;
          last_c = c;
        end
      end
      hold = m_valid && !m_ready;
      held = m_data;
      if (done === 1'b1) done_at = c;
    end
    m_ready = 1'b1;
    checks++;
    if (first != 1) begin
      errors++;
      $display("FAIL first_valid: cycle %0d expected 1 (base %0d)", first, base);
    end
    checks++;
    if (beats != len || exp_q.size() != 0) begin
      errors++;
      $display("FAIL beat_count: %0d beats, %0d left expected %0d beats", beats, exp_q.size(), len);
      exp_q.delete();
    end
    checks++;
    if (done_at < 0 || done_at != last_c + 2) begin
      errors++;
      $display("FAIL done_time: cycle %0d expected %0d", done_at, last_c + 2);
    end
    if (!rnd) begin
      checks++;
      if (last_c != first + len - 1) begin
        errors++;
        $display("FAIL throughput: last beat cycle %0d expected %0d", last_c, first + len - 1);
      end
    end
    checks++;
    if (ram_addr !== 10'(base + len)) begin
      errors++;
      $display("FAIL end_addr: ram_addr=%0d expected %0d", ram_addr, (base + len) % 1024);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({done, busy, m_valid} !== 3'b000) begin
        errors++;
        $display("FAIL after_done: done/busy/valid=%b expected 000", {done, busy, m_valid});
      end
    end
  endtask

  task automatic test_zero_length();
    int done_at, dones;
    bit vseen;
    done_at = -1; dones = 0; vseen = 1'b0;
    issue_start(5, 0, 1'b1);
    abort = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      abort = 1'b0;
      if (m_valid === 1'b1) vseen = 1'b1;
      if (done === 1'b1) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
    end
    checks++;
    if (done_at != 1 || dones != 1) begin
      errors++;
      $display("FAIL zero_done: first at %0d, %0d pulses expected 1 pulse at 1", done_at, dones);
    end
    checks++;
    if (vseen) begin
      errors++;
      $display("FAIL zero_valid: m_valid rose expected never");
    end
  endtask

  task automatic test_abort();
    m_ready = 1'b0;
    issue_start(0, 100, 1'b0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, m_valid} !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle: busy/valid=%b expected 00", {busy, m_valid});
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({done, m_valid} !== 2'b00) begin
        errors++;
        $display("FAIL abort_quiet: done/valid=%b expected 00", {done, m_valid});
      end
    end
    test_transfer(0, 4, 1'b0);
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    issue_start(0, 50, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, m_valid, m_last, m_data, ram_addr} !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b valid=%b last=%b data=%h addr=%0d expected all 0",
               busy, done, m_valid, m_last, m_data, ram_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_transfer(3, 5, 1'b1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_transfer(0, 16, 1'b0);
    test_transfer(1020, 8, 1'b0);
    test_transfer(100, 32, 1'b1);
    test_zero_length();
    test_transfer(512, 1024, 1'b0);
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
